// File: rtl/ser_neuron_pkg.sv
// Shared constants, state encoding and helpers for the neuron-grid SPI path.
package ser_neuron_pkg;

   localparam int unsigned DW    = 8;
   localparam int unsigned N_CH  = 8;
   localparam int unsigned SEL_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // One-hot channel mask for a channel index.
   function automatic logic [N_CH-1:0] sel_mask(input logic [SEL_W-1:0] sel);
      logic [N_CH-1:0] m;
      m      = '0;
      m[sel] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/input_distributor_if.sv
// Byte-write side and committed-channel side of the input distributor.
interface input_distributor_if;
   import ser_neuron_pkg::*;

   logic [DW-1:0]    din_spi;
   logic             din_valid;
   logic [SEL_W-1:0] input_select;
   logic             auto_inc;
   logic             broadcast;
   logic             commit_req;

   logic [DW-1:0]    din0;
   logic [DW-1:0]    din1;
   logic [DW-1:0]    din2;
   logic [DW-1:0]    din3;
   logic [DW-1:0]    din4;
   logic [DW-1:0]    din5;
   logic [DW-1:0]    din6;
   logic [DW-1:0]    din7;
   logic [N_CH-1:0]  load_strobe;
   logic [SEL_W-1:0] wr_ptr;
   logic             frame_done;
   logic             busy;

   modport master (
      output din_spi, din_valid, input_select, auto_inc, broadcast, commit_req,
      input  din0, din1, din2, din3, din4, din5, din6, din7,
      input  load_strobe, wr_ptr, frame_done, busy
   );

   modport slave (
      input  din_spi, din_valid, input_select, auto_inc, broadcast, commit_req,
      output din0, din1, din2, din3, din4, din5, din6, din7,
      output load_strobe, wr_ptr, frame_done, busy
   );

endinterface

// File: rtl/input_distributor.sv
// Routes SPI bytes into shadow registers and publishes them atomically to the
// eight neuron-input channels (addressed, auto-increment frame, broadcast).
module input_distributor
   import ser_neuron_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input_distributor_if.slave bus
);

   state_t           state;
   logic [DW-1:0]    shadow [N_CH];
   logic [DW-1:0]    din_q  [N_CH];
   logic [N_CH-1:0]  dirty;
   logic [N_CH-1:0]  load_strobe_q;
   logic [SEL_W-1:0] wr_ptr_q;
   logic             frame_done_q;
   logic             commit_wrap;

   logic [N_CH-1:0]  wmask_c;
   logic             auto_c;
   logic             wrap_c;
   logic             trigger_c;

   // Channels touched by this cycle's write; broadcast beats auto_inc beats select.
   always_comb begin
      wmask_c = '0;
      if (bus.din_valid) begin
         if (bus.broadcast)     wmask_c = '1;
         else if (bus.auto_inc) wmask_c = sel_mask(wr_ptr_q);
         else                   wmask_c = sel_mask(bus.input_select);
      end
   end

   assign auto_c    = bus.din_valid && bus.auto_inc && !bus.broadcast;
   assign wrap_c    = auto_c && (wr_ptr_q == SEL_W'(N_CH - 1));
   assign trigger_c = bus.commit_req || wrap_c || (bus.din_valid && bus.broadcast);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         dirty         <= '0;
         load_strobe_q <= '0;
         wr_ptr_q      <= '0;
         frame_done_q  <= 1'b0;
         commit_wrap   <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            shadow[i] <= '0;
            din_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (wmask_c[i]) shadow[i] <= bus.din_spi;
         end
         if (auto_c) wr_ptr_q <= wr_ptr_q + SEL_W'(1);

         load_strobe_q <= '0;
         frame_done_q  <= 1'b0;

         case (state)
            IDLE, FILL: begin
               dirty <= dirty | wmask_c;
               // An idle commit_req with nothing pending or arriving is dropped.
               if (trigger_c && (state == FILL || bus.din_valid)) begin
                  state       <= COMMIT;
                  commit_wrap <= wrap_c;
               end else if (bus.din_valid) begin
                  state <= FILL;
               end
            end
            COMMIT: begin
               for (int i = 0; i < N_CH; i++) begin
                  if (dirty[i]) din_q[i] <= shadow[i];
               end
               load_strobe_q <= dirty;
               frame_done_q  <= commit_wrap;
               commit_wrap   <= 1'b0;
               // A write landing now starts the next batch rather than joining this one.
               dirty <= wmask_c;
               state <= bus.din_valid ? FILL : IDLE;
            end
            default: begin
               state <= IDLE;
               dirty <= '0;
            end
         endcase
      end
   end

   assign bus.din0        = din_q[0];
   assign bus.din1        = din_q[1];
   assign bus.din2        = din_q[2];
   assign bus.din3        = din_q[3];
   assign bus.din4        = din_q[4];
   assign bus.din5        = din_q[5];
   assign bus.din6        = din_q[6];
   assign bus.din7        = din_q[7];
   assign bus.load_strobe = load_strobe_q;
   assign bus.wr_ptr      = wr_ptr_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.busy        = (state == COMMIT);

endmodule

// File: tb/tb_input_distributor.sv
// Self-checking bench for input_distributor: directed vector table, hand-written
// frame/broadcast/reset sequences, and a randomized run against a mask-level model.
module tb_input_distributor;
   import ser_neuron_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   input_distributor_if bus();

   input_distributor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: pending mask + "commit scheduled" flag
   logic [7:0] m_sh  [8];
   logic [7:0] m_din [8];
   logic [7:0] m_pend;
   bit         m_go;
   bit         m_go_wrap;
   logic [2:0] m_ptr;
   logic [7:0] e_strobe;
   bit         e_fd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] get_din(input int i);
      case (i)
         0: return bus.din0;
         1: return bus.din1;
         2: return bus.din2;
         3: return bus.din3;
         4: return bus.din4;
         5: return bus.din5;
         6: return bus.din6;
         default: return bus.din7;
      endcase
   endfunction

   task automatic model(input bit r, input bit v, input logic [2:0] sel, input bit ai,
                        input bit bc, input bit cr, input logic [7:0] d);
      logic [7:0] mask;
      bit         wrap;
      if (r) begin
         for (int i = 0; i < 8; i++) begin
            m_sh[i]  = 8'h00;
            m_din[i] = 8'h00;
         end
         m_pend = 8'h00; m_go = 0; m_go_wrap = 0; m_ptr = 3'd0;
         e_strobe = 8'h00; e_fd = 0;
         return;
      end
      mask = 8'h00;
      if (v) mask = bc ? 8'hFF : (8'(1) << (ai ? m_ptr : sel));
      wrap = v && ai && !bc && (m_ptr == 3'd7);
      if (m_go) begin
         for (int i = 0; i < 8; i++) if (m_pend[i]) m_din[i] = m_sh[i];
         e_strobe = m_pend;
         e_fd     = m_go_wrap;
         m_pend   = mask;
         m_go     = 0;
      end else begin
         e_strobe  = 8'h00;
         e_fd      = 0;
         m_pend    = m_pend | mask;
         m_go      = (cr && m_pend != 8'h00) || wrap || (v && bc);
         m_go_wrap = wrap;
      end
      for (int i = 0; i < 8; i++) if (mask[i]) m_sh[i] = d;
      if (v && ai && !bc) m_ptr = m_ptr + 3'd1;
   endtask

   task automatic compare_all();
      for (int i = 0; i < 8; i++) check($sformatf("din%0d", i), 32'(get_din(i)), 32'(m_din[i]));
      check("load_strobe", 32'(bus.load_strobe), 32'(e_strobe));
      check("frame_done", 32'(bus.frame_done), 32'(e_fd));
      check("wr_ptr", 32'(bus.wr_ptr), 32'(m_ptr));
      check("busy", 32'(bus.busy), 32'(m_go));
   endtask

   task automatic step(input bit r, input bit v, input int sel, input bit ai, input bit bc,
                       input bit cr, input int d);
      rst              = r;
      bus.din_valid    = v;
      bus.input_select = 3'(sel);
      bus.auto_inc     = ai;
      bus.broadcast    = bc;
      bus.commit_req   = cr;
      bus.din_spi      = 8'(d);
      @(posedge clk);
      #1;
      model(r, v, 3'(sel), ai, bc, cr, 8'(d));
      compare_all();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   typedef struct {
      bit         r, v;
      logic [2:0] sel;
      bit         ai, bc, cr;
      logic [7:0] d;
      logic [7:0] e_strobe;
      bit         e_busy;
      int         ch;
      logic [7:0] e_val;
   } vec_t;

   vec_t vecs [$];

   function automatic vec_t mk(bit r, bit v, int sel, bit cr, int d,
                               int es, bit eb, int ch, int ev);
      vec_t t;
      t.r = r; t.v = v; t.sel = 3'(sel); t.ai = 0; t.bc = 0; t.cr = cr; t.d = 8'(d);
      t.e_strobe = 8'(es); t.e_busy = eb; t.ch = ch; t.e_val = 8'(ev);
      return t;
   endfunction

   initial begin
      rst              = 1'b1;
      bus.din_valid    = 1'b0;
      bus.input_select = '0;
      bus.auto_inc     = 1'b0;
      bus.broadcast    = 1'b0;
      bus.commit_req   = 1'b0;
      bus.din_spi      = '0;

      // Addressed write + commit; repeat writes and coincident commit; write during COMMIT.
      vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 3, 8'h00));
      vecs.push_back(mk(0, 1, 3, 0, 8'hA5, 8'h00, 0, 3, 8'h00));
      vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 1, 3, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h08, 0, 3, 8'hA5));
      vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 0, 3, 8'hA5));
      vecs.push_back(mk(0, 1, 5, 0, 8'h11, 8'h00, 0, 5, 8'h00));
      vecs.push_back(mk(0, 1, 5, 0, 8'h22, 8'h00, 0, 5, 8'h00));
      vecs.push_back(mk(0, 1, 1, 1, 8'h33, 8'h00, 1, 1, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h22, 0, 5, 8'h22));
      vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h33));
      vecs.push_back(mk(0, 1, 6, 1, 8'h55, 8'h00, 1, 6, 8'h00));
      vecs.push_back(mk(0, 1, 2, 0, 8'h44, 8'h40, 0, 6, 8'h55));
      vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 1, 2, 8'h00));
      vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h04, 0, 2, 8'h44));
      vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 2, 8'h44));

      foreach (vecs[k]) begin
         step(vecs[k].r, vecs[k].v, int'(vecs[k].sel), vecs[k].ai, vecs[k].bc, vecs[k].cr,
              int'(vecs[k].d));
         check($sformatf("vec%0d_strobe", k), 32'(bus.load_strobe), 32'(vecs[k].e_strobe));
         check($sformatf("vec%0d_busy", k), 32'(bus.busy), 32'(vecs[k].e_busy));
         check($sformatf("vec%0d_din%0d", k, vecs[k].ch), 32'(get_din(vecs[k].ch)),
               32'(vecs[k].e_val));
      end

      // Auto-increment frame: nothing published until the eighth byte wraps.
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 0, 1, 0, 0, 8'h10 + i);
         check("frame_no_early_strobe", 32'(bus.load_strobe), 32'h0);
         check("frame_busy", 32'(bus.busy), (i == 7) ? 32'h1 : 32'h0);
      end
      idle();
      check("frame_strobe", 32'(bus.load_strobe), 32'hFF);
      check("frame_done", 32'(bus.frame_done), 32'h1);
      check("frame_wr_ptr", 32'(bus.wr_ptr), 32'h0);
      for (int i = 0; i < 8; i++) check("frame_din", 32'(get_din(i)), 32'h10 + 32'(i));
      idle();
      check("frame_done_once", 32'(bus.frame_done), 32'h0);

      // Broadcast from FILL with channel 2 dirty, wr_ptr left at 2.
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 0, 8'h01);
      step(0, 1, 0, 1, 0, 1, 8'h02);
      idle();
      step(0, 1, 2, 0, 0, 0, 8'h77);
      step(0, 1, 0, 1, 1, 0, 8'h3C);
      check("bcast_busy", 32'(bus.busy), 32'h1);
      idle();
      check("bcast_strobe", 32'(bus.load_strobe), 32'hFF);
      check("bcast_wr_ptr", 32'(bus.wr_ptr), 32'h2);
      check("bcast_frame_done", 32'(bus.frame_done), 32'h0);
      for (int i = 0; i < 8; i++) check("bcast_din", 32'(get_din(i)), 32'h3C);

      // Reset mid-frame discards everything; a following commit_req does nothing.
      for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 0, 8'hC0 + i);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      idle();
      check("rst_strobe", 32'(bus.load_strobe), 32'h0);
      check("rst_wr_ptr", 32'(bus.wr_ptr), 32'h0);
      for (int i = 0; i < 8; i++) check("rst_din", 32'(get_din(i)), 32'h0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         bit r, v, ai, bc, cr;
         r  = ($urandom_range(0, 199) == 0);
         v  = ($urandom_range(0, 99) < 55);
         ai = ($urandom_range(0, 99) < 45);
         bc = ($urandom_range(0, 99) < 5);
         cr = ($urandom_range(0, 99) < 15);
         step(r, v, int'($urandom_range(0, 7)), ai, bc, cr, int'($urandom_range(0, 255)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
